// File: rtl/puf_pkg.sv
// Shared definitions for the PUF readout controller: response geometry and FSM states.
package puf_pkg;

    localparam int PUF_W       = 1024;
    localparam int CHALLENGE_W = 2;
    localparam int CNT_W       = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WARMUP   = 3'd1,
        CAPTURE1 = 3'd2,
        RECHECK  = 3'd3,
        CAPTURE2 = 3'd4,
        READOUT  = 3'd5,
        DONE     = 3'd6
    } puf_state_e;

endpackage

// File: rtl/puf_word_serializer.sv
// Holds the captured 1024-bit response and presents it as WORD_W-bit words, LSW first.
module puf_word_serializer
    import puf_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [PUF_W-1:0]  resp_i,
    input  logic              handshake_i,
    output logic [WORD_W-1:0] word_o,
    output logic              last_o,
    output logic              differs_o
);

    localparam int NW    = PUF_W / WORD_W;
    localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;

    logic [NW-1:0][WORD_W-1:0] buf_q;
    logic [IDX_W-1:0]          idx_q;
    logic [IDX_W-1:0]          idx_d;

    // Response storage carries no reset; it is only visible through out_data during READOUT.
    always_ff @(posedge clk) begin
        if (load_i) begin
            buf_q <= resp_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    always_comb begin
        idx_d = idx_q;
        if (load_i) begin
            idx_d = '0;
        end else if (handshake_i && !last_o) begin
            idx_d = idx_q + 1'b1;
        end
    end

    assign last_o    = (idx_q == IDX_W'(NW - 1));
    assign word_o    = buf_q[idx_q];
    assign differs_o = (resp_i != buf_q);

endmodule

// File: rtl/puf_readout_ctrl.sv
// PUF evaluation sequencer: warm-up, double capture with stability check, then word readout.
//
// state    | meaning
// IDLE     | waiting for start; latches challenge and clears unstable on acceptance
// WARMUP   | generator enabled for WARMUP_CYCLES before the first capture
// CAPTURE1 | response registered into the buffer
// RECHECK  | generator kept enabled for RECHECK_CYCLES
// CAPTURE2 | response compared against the buffer; mismatch sets unstable
// READOUT  | buffer streamed out word by word under valid/ready
// DONE     | one-cycle done pulse, then back to IDLE
module puf_readout_ctrl
    import puf_pkg::*;
#(
    parameter int WARMUP_CYCLES  = 16,
    parameter int RECHECK_CYCLES = 8,
    parameter int WORD_W         = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CHALLENGE_W-1:0] challenge,
    output logic                   busy,
    output logic                   puf_enable,
    output logic [CHALLENGE_W-1:0] puf_control,
    input  logic [PUF_W-1:0]       puf_response,
    output logic [WORD_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   unstable,
    output logic                   done
);

    if (WARMUP_CYCLES < 1 || WARMUP_CYCLES > 255) begin : g_bad_warmup
        $error("WARMUP_CYCLES must be in 1..255");
    end
    if (RECHECK_CYCLES < 1 || RECHECK_CYCLES > 255) begin : g_bad_recheck
        $error("RECHECK_CYCLES must be in 1..255");
    end
    if (PUF_W % WORD_W != 0) begin : g_bad_word
        $error("WORD_W must divide 1024");
    end

    puf_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CHALLENGE_W-1:0] chal_q, chal_d;
    logic                   unstable_q, unstable_d;
    logic                   load;
    logic                   handshake;
    logic                   ser_last;
    logic                   ser_differs;
    logic [WORD_W-1:0]      ser_word;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            chal_q     <= '0;
            unstable_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            chal_q     <= chal_d;
            unstable_q <= unstable_d;
        end
    end

    // Timed states load count-1 on entry and leave when the down-counter reaches zero.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        chal_d     = chal_q;
        unstable_d = unstable_q;
        load       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    chal_d     = challenge;
                    unstable_d = 1'b0;
                    cnt_d      = CNT_W'(WARMUP_CYCLES - 1);
                    state_d    = WARMUP;
                end
            end
            WARMUP: begin
                if (cnt_q == '0) begin
                    state_d = CAPTURE1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CAPTURE1: begin
                load    = 1'b1;
                cnt_d   = CNT_W'(RECHECK_CYCLES - 1);
                state_d = RECHECK;
            end
            RECHECK: begin
                if (cnt_q == '0) begin
                    state_d = CAPTURE2;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CAPTURE2: begin
                if (ser_differs) begin
                    unstable_d = 1'b1;
                end
                cnt_d   = '0;
                state_d = READOUT;
            end
            READOUT: begin
                if (out_ready && ser_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign handshake = (state_q == READOUT) && out_ready;

    puf_word_serializer #(
        .WORD_W (WORD_W)
    ) u_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load),
        .resp_i      (puf_response),
        .handshake_i (handshake),
        .word_o      (ser_word),
        .last_o      (ser_last),
        .differs_o   (ser_differs)
    );

    assign busy        = (state_q != IDLE);
    assign puf_enable  = (state_q == WARMUP) || (state_q == CAPTURE1) ||
                         (state_q == RECHECK) || (state_q == CAPTURE2);
    assign puf_control = chal_q;
    assign out_valid   = (state_q == READOUT);
    assign out_last    = (state_q == READOUT) && ser_last;
    assign out_data    = (state_q == READOUT) ? ser_word : '0;
    assign done        = (state_q == DONE);
    assign unstable    = unstable_q;

endmodule

// File: tb/tb_puf_readout_ctrl.sv
// Self-checking bench for puf_readout_ctrl: cycle-level reference model plus directed scenarios.
module tb_puf_readout_ctrl;

    localparam int WU = 16;
    localparam int RC = 8;
    localparam int WW = 32;
    localparam int NW = 1024 / WW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [1:0]      challenge;
    logic            busy;
    logic            puf_enable;
    logic [1:0]      puf_control;
    logic [1023:0]   puf_response;
    logic [WW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            unstable;
    logic            done;

    always #5 clk = ~clk;

    puf_readout_ctrl #(
        .WARMUP_CYCLES  (WU),
        .RECHECK_CYCLES (RC),
        .WORD_W         (WW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .challenge    (challenge),
        .busy         (busy),
        .puf_enable   (puf_enable),
        .puf_control  (puf_control),
        .puf_response (puf_response),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .unstable     (unstable),
        .done         (done)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an evaluation is a timeline t=1..WU+RC+2 with the generator on,
    // capture at the end of t=WU+1, compare at the end of t=WU+RC+2, then NW handshakes.
    bit            m_busy    = 0;
    bit            m_reading = 0;
    bit            m_done    = 0;
    bit            m_unst    = 0;
    int            m_t       = 0;
    int            m_k       = 0;
    logic [1:0]    m_ctrl    = '0;
    logic [1023:0] m_buf     = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_reading = 0; m_done = 0; m_unst = 0;
            m_t = 0; m_k = 0; m_ctrl = '0;
        end else if (m_done) begin
            m_done = 0;
            m_busy = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1; m_t = 1; m_ctrl = challenge; m_unst = 0;
            end
        end else if (!m_reading) begin
            if (m_t == WU + 1) m_buf = puf_response;
            if (m_t == WU + RC + 2) begin
                m_unst    = (puf_response != m_buf);
                m_reading = 1;
                m_k       = 0;
            end
            m_t++;
        end else if (out_ready) begin
            if (m_k == NW - 1) begin
                m_reading = 0;
                m_done    = 1;
            end else begin
                m_k++;
            end
        end
    end

    int          cyc = 0;
    int          en_cnt = 0;
    int          done_cnt = 0;
    int          last_cyc = 0;
    int          done_cyc = 0;
    int          first_v_cyc = 0;
    logic [WW-1:0] acc[$];
    bit          prev_v = 0;
    bit          prev_r = 0;
    logic [WW-1:0] prev_d = '0;

    always @(negedge clk) begin
        cyc++;
        chk("busy",        busy,        m_busy);
        chk("puf_enable",  puf_enable,  m_busy && !m_reading && !m_done);
        chk("puf_control", puf_control, m_ctrl);
        chk("out_valid",   out_valid,   m_reading);
        chk("out_last",    out_last,    m_reading && (m_k == NW - 1));
        chk("done",        done,        m_done);
        chk("unstable",    unstable,    m_unst);
        chk("out_data",    out_data,    m_reading ? m_buf[m_k*WW +: WW] : '0);
        if (prev_v && !prev_r && out_valid) chk("stall_hold", out_data, prev_d);
        if (puf_enable) en_cnt++;
        if (out_valid && !prev_v) first_v_cyc = cyc;
        if (out_valid && out_ready) begin
            acc.push_back(out_data);
            if (out_last) last_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_v = out_valid;
        prev_r = out_ready;
        prev_d = out_data;
    end

    bit rdy_mode = 0;
    bit rpat[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    int rph      = 0;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (rdy_mode) begin
                out_ready = rpat[rph];
                rph       = (rph + 1) % 4;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    task automatic start_eval(input logic [1:0] ch);
        @(posedge clk); #2;
        challenge = ch;
        start     = 1'b1;
        en_cnt    = 0;
        acc.delete();
        @(posedge clk); #2;
        start     = 1'b0;
        challenge = 2'b00;
    endtask

    task automatic wait_done(input bit poke_start);
        bit ok;
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1;
                if (poke_start) start = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL done_timeout: no done within 600 cycles (t=%0t)", $time);
        end
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic check_words(input string name, input logic [1023:0] exp);
        chk({name, "_count"}, acc.size(), NW);
        for (int i = 0; i < acc.size() && i < NW; i++) begin
            chk(name, acc[i], exp[i*WW +: WW]);
        end
    endtask

    logic [1023:0] pat_p;
    logic [1023:0] pat_q;
    int            dc;
    bit            hit;

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        challenge    = 2'b00;
        puf_response = '0;
        for (int k = 0; k < NW; k++) begin
            pat_p[k*WW +: WW] = 32'hA500_0000 | (32'(k) * 32'h0001_0101);
            pat_q[k*WW +: WW] = 32'h5A00_0000 | (32'(k) * 32'h0003_0007);
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",     busy,        1'b0);
        chk("rst_out_data", out_data,    '0);
        chk("rst_control",  puf_control, 2'b00);
        chk("rst_unstable", unstable,    1'b0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Constant response 0x123, ready always high.
        puf_response = 1024'h123;
        start_eval(2'b10);
        @(negedge clk);
        chk("t1_busy_next",  busy,        1'b1);
        chk("t1_control",    puf_control, 2'b10);
        dc = done_cnt;
        wait_done(1'b0);
        chk("t1_enable_cycles", en_cnt, 26);
        check_words("t1_word", 1024'h123);
        if (acc.size() > 0) chk("t1_word0", acc[0], 32'h0000_0123);
        chk("t1_consecutive", last_cyc - first_v_cyc, NW - 1);
        chk("t1_done_after_last", done_cyc - last_cyc, 1);
        chk("t1_unstable", unstable, 1'b0);
        chk("t1_done_count", done_cnt - dc, 1);

        // Bit 700 flips during RECHECK: flagged unstable, first capture is read out.
        puf_response = pat_p;
        start_eval(2'b01);
        repeat (19) @(posedge clk);
        #2;
        puf_response[700] = ~puf_response[700];
        wait_done(1'b0);
        check_words("t2_word", pat_p);
        if (acc.size() > 21) chk("t2_word21", acc[21], 32'hA515_1515);
        chk("t2_unstable", unstable, 1'b1);
        repeat (3) @(negedge clk);
        chk("t2_unstable_held", unstable, 1'b1);
        puf_response = pat_p;

        // Stalling consumer plus start pulses in WARMUP and DONE.
        rdy_mode = 1;
        dc = done_cnt;
        start_eval(2'b11);
        chk("t3_unstable_cleared", unstable, 1'b0);
        repeat (3) @(posedge clk);
        #2; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        wait_done(1'b1);
        rdy_mode = 0;
        check_words("t3_word", pat_p);
        repeat (6) @(negedge clk);
        chk("t3_idle_busy", busy, 1'b0);
        chk("t3_done_count", done_cnt - dc, 1);

        // Reset while word 10 is presented.
        start_eval(2'b01);
        hit = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #3;
            if (acc.size() >= 10) begin
                hit = 1;
                break;
            end
        end
        chk("t4_reached_word10", hit, 1'b1);
        rst_n = 1'b0;
        dc = done_cnt;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t4_valid_after_rst", out_valid, 1'b0);
        chk("t4_busy_after_rst",  busy,      1'b0);
        repeat (40) @(posedge clk);
        chk("t4_no_done", done_cnt - dc, 0);
        puf_response = pat_q;
        start_eval(2'b10);
        wait_done(1'b0);
        check_words("t4_word", pat_q);
        if (acc.size() > 0) chk("t4_word0", acc[0], 32'h5A00_0000);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
